// File: rtl/fetch_pc_unit_pkg.sv
// fetch_pc_unit_pkg: opcodes, fetch FSM states and the IF/ID packet shared by
// the fetch PC unit and its predecoder. Optional feature macro: FETCH_BTB_EN.

// Fall back to the standard machine widths when the system header has not
// already provided them.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef WIDTH
`define WIDTH 2
`endif

package fetch_pc_unit_pkg;

  // RV32 major opcodes that redirect control flow.
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } FETCH_STATE;

  typedef struct packed {
    logic [31:0]       inst;
    logic [`XLEN-1:0]  pc;
    logic              valid;
    logic              pred_taken;
    logic [`XLEN-1:0]  pred_tpc;
  } IF_ID_packet;

  // Major opcode field of an instruction word.
  function automatic logic [6:0] opcode_of(input logic [31:0] inst);
    return inst[6:0];
  endfunction

endpackage

// File: rtl/fetch_pc_unit_predecode.sv
// predecode: flags control-flow instructions in one fetch slot and computes the
// 12-bit BTB index (word address bits [13:2]) of the static next PC.

module predecode
  import fetch_pc_unit_pkg::*;
(
  input  logic [31:0]      inst,
  input  logic [`XLEN-1:0] pc,
  output logic             branch_en,
  output logic             uncond_en,
  output logic [11:0]      npc
);

  logic [6:0]       opcode;
  logic [`XLEN-1:0] imm_j;
  logic [`XLEN-1:0] imm_b;
  logic [`XLEN-1:0] target;
  logic [`XLEN-1:0] link;
  logic             unused_bits;

  assign opcode = opcode_of(inst);

  // J-type and B-type immediates, sign extended to the full address width.
  assign imm_j = {{(`XLEN-21){inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign imm_b = {{(`XLEN-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};

  assign target = pc + ((opcode == OPC_JAL) ? imm_j : imm_b);
  assign link   = pc + `XLEN'(4);

  // Only the BTB index bits of the sums are consumed.
  assign unused_bits = ^{target[`XLEN-1:14], target[1:0], link[`XLEN-1:14], link[1:0]};

  // Classify the opcode and select the static successor index.
  always_comb begin
    branch_en = 1'b0;
    uncond_en = 1'b0;
    npc       = link[13:2];
    case (opcode)
      OPC_JAL: begin
        branch_en = 1'b1;
        uncond_en = 1'b1;
        npc       = target[13:2];
      end
      OPC_JALR: begin
        branch_en = 1'b1;
        uncond_en = 1'b1;
        npc       = link[13:2];
      end
      OPC_BRANCH: begin
        branch_en = 1'b1;
        npc       = target[13:2];
      end
      default: begin
        branch_en = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: owns the fetch PC, issues I-cache requests, predecodes the
// returned bundle, applies BTB predictions and hands the bundle to decode.
// The bundle is bypassed combinationally in the cycle the response arrives and
// is held in registers while decode stalls. Retire-time redirects bump an
// epoch so responses belonging to the squashed stream are discarded.
// Optional feature macro: FETCH_BTB_EN enables BTB-directed prediction; without
// it every slot is valid and fetch is strictly sequential.

module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter logic [`XLEN-1:0] RESET_PC = 32'h0,
  parameter int               FQ_TAG_W = 2
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          rob_redirect_en,
  input  logic [`XLEN-1:0]              rob_redirect_pc,
  input  logic [`WIDTH-1:0]             btb_hit,
  input  logic [`WIDTH-1:0][`XLEN-1:0]  btb_tpc,
  input  logic                          mem_valid,
  input  logic [`WIDTH-1:0][31:0]       mem_data,
  input  logic                          dec_stall,
  output logic                          mem_req,
  output logic [`XLEN-1:0]              mem_addr,
  output logic [`WIDTH-1:0][`XLEN-1:0]  fetch_pc,
  output logic [`WIDTH-1:0]             branch_en,
  output logic [`WIDTH-1:0]             uncond_en,
  output logic [`WIDTH-1:0][11:0]       npc,
  output logic [`WIDTH-1:0]             if_valid,
  output logic [`WIDTH-1:0][31:0]       if_inst,
  output logic [`WIDTH-1:0][`XLEN-1:0]  if_pc,
  output logic [`WIDTH-1:0]             if_pred_taken,
  output logic [`WIDTH-1:0][`XLEN-1:0]  if_pred_tpc
);

  localparam logic [`XLEN-1:0] BUNDLE_BYTES = `XLEN'(4 * `WIDTH);

  FETCH_STATE            state_q;
  logic [`XLEN-1:0]      pc_q;
  logic [`XLEN-1:0]      hold_npc_q;
  logic [FQ_TAG_W-1:0]   epoch_q;
  logic [FQ_TAG_W-1:0]   req_tag_q;
  logic [FQ_TAG_W-1:0]   resp_tag;
  IF_ID_packet           hold_pkt_q [`WIDTH];
  IF_ID_packet           live_pkt   [`WIDTH];
  IF_ID_packet           out_pkt    [`WIDTH];

  logic [`WIDTH-1:0]     taken_vec;
  logic [`WIDTH-1:0]     taken_oh;
  logic [`WIDTH-1:0]     valid_mask;
  logic                  any_taken;
  logic [`XLEN-1:0]      taken_tpc;
  logic [`XLEN-1:0]      seq_npc;
  logic [`XLEN-1:0]      next_pc_d;
  logic                  accept;
  logic                  show_live;
  logic                  show_hold;

`ifdef FETCH_BTB_EN
  // A slot redirects fetch only when predecode sees control flow and the BTB hits.
  assign taken_vec = branch_en & btb_hit;
`else
  logic unused_btb;
  assign unused_btb = ^btb_hit;
  assign taken_vec  = '0;
`endif

  // Find the first taken slot; it and everything before it stay valid.
  always_comb begin
    any_taken  = 1'b0;
    taken_oh   = '0;
    valid_mask = '0;
    taken_tpc  = '0;
    for (int i = 0; i < `WIDTH; i++) begin
      if (!any_taken) begin
        valid_mask[i] = 1'b1;
        if (taken_vec[i]) begin
          any_taken   = 1'b1;
          taken_oh[i] = 1'b1;
          taken_tpc   = btb_tpc[i];
        end
      end
    end
  end

  // Sequential successor wraps naturally at the top of the address space.
  assign seq_npc   = pc_q + BUNDLE_BYTES;
  assign next_pc_d = any_taken ? taken_tpc : seq_npc;

  // A request issued this cycle carries the live epoch; with no request
  // outstanding the response belongs to whatever was issued last, which after a
  // redirect is always the previous epoch.
  assign resp_tag = (state_q == FETCH) ? epoch_q : req_tag_q;

  assign accept    = !reset && !rob_redirect_en && mem_valid &&
                     (state_q != HOLD) && (resp_tag == epoch_q);
  assign show_live = accept;
  assign show_hold = !reset && !rob_redirect_en && (state_q == HOLD);

  assign mem_req  = !reset && !rob_redirect_en && (state_q == FETCH);
  assign mem_addr = reset ? '0 : pc_q;

  for (genvar gi = 0; gi < `WIDTH; gi++) begin : g_slot
    assign fetch_pc[gi] = pc_q + `XLEN'(4 * gi);

    predecode u_predecode (
      .inst      (mem_data[gi]),
      .pc        (fetch_pc[gi]),
      .branch_en (branch_en[gi]),
      .uncond_en (uncond_en[gi]),
      .npc       (npc[gi])
    );

    assign live_pkt[gi] = '{
      inst:       mem_data[gi],
      pc:         fetch_pc[gi],
      valid:      valid_mask[gi],
      pred_taken: taken_oh[gi],
      pred_tpc:   taken_oh[gi] ? btb_tpc[gi] : (fetch_pc[gi] + `XLEN'(4))
    };

    // Fresh response bypasses the hold register; otherwise show the held copy.
    assign out_pkt[gi] = show_live ? live_pkt[gi] :
                         (show_hold ? hold_pkt_q[gi] : '0);

    assign if_valid[gi]      = out_pkt[gi].valid;
    assign if_inst[gi]       = out_pkt[gi].inst;
    assign if_pc[gi]         = out_pkt[gi].pc;
    assign if_pred_taken[gi] = out_pkt[gi].pred_taken;
    assign if_pred_tpc[gi]   = out_pkt[gi].pred_tpc;
  end

  // Fetch FSM: reset beats redirect, redirect beats stall and responses.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      epoch_q    <= '0;
      req_tag_q  <= '0;
      hold_npc_q <= '0;
      for (int i = 0; i < `WIDTH; i++) begin
        hold_pkt_q[i] <= '0;
      end
    end else if (rob_redirect_en) begin
      state_q   <= FLUSH;
      pc_q      <= rob_redirect_pc;
      req_tag_q <= epoch_q;
      epoch_q   <= epoch_q + 1'b1;
      for (int i = 0; i < `WIDTH; i++) begin
        hold_pkt_q[i] <= '0;
      end
    end else begin
      case (state_q)
        FETCH: begin
          req_tag_q <= epoch_q;
          if (accept) begin
            if (dec_stall) begin
              state_q    <= HOLD;
              hold_npc_q <= next_pc_d;
              for (int i = 0; i < `WIDTH; i++) begin
                hold_pkt_q[i] <= live_pkt[i];
              end
            end else begin
              pc_q <= next_pc_d;
            end
          end
        end
        HOLD: begin
          if (!dec_stall) begin
            state_q <= FETCH;
            pc_q    <= hold_npc_q;
          end
        end
        FLUSH: begin
          state_q <= FETCH;
        end
        default: begin
          state_q <= FETCH;
        end
      endcase
    end
  end

endmodule
